// File: rtl/dot_product_sequencer.sv
// Control FSM sequencing one dot-product job: LOAD -> COMPUTE -> COMMIT -> writeback -> DONE.
// Optional DOTP_SEQ_PERF_EN adds perf_cycles/perf_stalls job counters.
module dot_product_sequencer #(
    parameter int Addr_Width           = 4,
    parameter int Nums_Data            = 16,
    parameter int Nums_Pipeline_Stages = 4,
    parameter int Para_Deg             = 1,
    parameter int Step_Width           = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  load_old_output,
    input  logic [Addr_Width-1:0] result_addr,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  mem_we_in,
    output logic [Addr_Width-1:0] mem_waddr,
    output logic                  mem_re,
    output logic [Addr_Width-1:0] mem_raddr,
    output logic                  pe_clear,
    output logic                  pe_valid,
    output logic                  pe_load_old,
    output logic                  out_we,
    output logic                  out_re,
    output logic [Addr_Width-1:0] out_addr,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  busy,
    output logic                  done,
    output logic [Step_Width-1:0] step
`ifdef DOTP_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`endif
);

    localparam int Beats = Nums_Data / Para_Deg;
    localparam logic [Step_Width-1:0] BeatsW   = Step_Width'(Beats);
    localparam logic [Step_Width-1:0] LastBeat = Step_Width'(Beats - 1);
    localparam logic [Step_Width-1:0] LastStep = Step_Width'(Beats + Nums_Pipeline_Stages - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_COMMIT,
        S_WB_READ,
        S_WB_SEND,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [Step_Width-1:0] step_q, step_d;
    logic                  load_old_q, load_old_d;
    logic [Addr_Width-1:0] result_addr_q, result_addr_d;
    logic                  pe_clear_q, pe_clear_d;
    logic                  pe_valid_q, pe_valid_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            load_old_q    <= 1'b0;
            result_addr_q <= '0;
            pe_clear_q    <= 1'b0;
            pe_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            load_old_q    <= load_old_d;
            result_addr_q <= result_addr_d;
            pe_clear_q    <= pe_clear_d;
            pe_valid_q    <= pe_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        load_old_d    = load_old_q;
        result_addr_d = result_addr_q;
        pe_clear_d    = 1'b0;
        load_ready    = 1'b0;
        mem_we_in     = 1'b0;
        mem_waddr     = '0;
        mem_re        = 1'b0;
        mem_raddr     = '0;
        pe_load_old   = 1'b0;
        out_we        = 1'b0;
        out_re        = 1'b0;
        out_addr      = '0;
        wb_valid      = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_old_d    = load_old_output;
                    result_addr_d = result_addr;
                    step_d        = '0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                mem_waddr  = step_q[Addr_Width-1:0];
                if (load_valid) begin
                    mem_we_in = 1'b1;
                    if (step_q == LastBeat) begin
                        step_d     = '0;
                        pe_clear_d = 1'b1;
                        state_d    = S_COMPUTE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                // Reads stop after the last beat; remaining steps drain the PE pipeline.
                if (step_q < BeatsW) begin
                    mem_re    = 1'b1;
                    mem_raddr = step_q[Addr_Width-1:0];
                end
                pe_load_old = load_old_q && (step_q == '0);
                if (step_q == LastStep) begin
                    step_d  = '0;
                    state_d = S_COMMIT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_COMMIT: begin
                out_we   = 1'b1;
                out_addr = result_addr_q;
                step_d   = '0;
                state_d  = S_WB_READ;
            end
            S_WB_READ: begin
                out_re   = 1'b1;
                out_addr = step_q[Addr_Width-1:0];
                state_d  = S_WB_SEND;
            end
            S_WB_SEND: begin
                // Address held so the output SRAM keeps driving the same word until accepted.
                wb_valid = 1'b1;
                out_addr = step_q[Addr_Width-1:0];
                if (wb_ready) begin
                    if (step_q == LastBeat) begin
                        step_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_WB_READ;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Input SRAM read data arrives one cycle after mem_re.
        pe_valid_d = mem_re;
    end

    assign pe_clear = pe_clear_q;
    assign pe_valid = pe_valid_q;
    assign busy     = (state_q != S_IDLE);
    assign step     = step_q;

`ifdef DOTP_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (state_q == S_IDLE) begin
            // The accepting IDLE cycle is counted as the first cycle of the job.
            if (start) begin
                perf_cycles_d = 32'd1;
                perf_stalls_d = '0;
            end
        end else begin
            perf_cycles_d = perf_cycles_q + 32'd1;
            if ((state_q == S_LOAD && !load_valid) || (state_q == S_WB_SEND && !wb_ready)) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: builds each job's expected cycle timeline from its own
// input sequence (beat counts, phase lengths) and compares every output every cycle.
module tb_dot_product_sequencer;

    localparam int AW     = 4;
    localparam int SW     = 6;
    localparam int BEATS  = 16;
    localparam int STAGES = 4;
    localparam int MAXT   = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          load_old_output;
    logic [AW-1:0] result_addr;
    logic          load_valid;
    logic          load_ready;
    logic          mem_we_in;
    logic [AW-1:0] mem_waddr;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic          pe_clear;
    logic          pe_valid;
    logic          pe_load_old;
    logic          out_we;
    logic          out_re;
    logic [AW-1:0] out_addr;
    logic          wb_valid;
    logic          wb_ready;
    logic          busy;
    logic          done;
    logic [SW-1:0] step;
`ifdef DOTP_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stalls;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          lr;
        logic          we;
        logic [AW-1:0] wa;
        logic          re;
        logic [AW-1:0] ra;
        logic          clr;
        logic          pv;
        logic          plo;
        logic          owe;
        logic          ore;
        logic [AW-1:0] oa;
        logic          wv;
        logic          busy;
        logic          done;
        logic [SW-1:0] step;
    } vec_t;

    dot_product_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .load_old_output (load_old_output),
        .result_addr     (result_addr),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .mem_we_in       (mem_we_in),
        .mem_waddr       (mem_waddr),
        .mem_re          (mem_re),
        .mem_raddr       (mem_raddr),
        .pe_clear        (pe_clear),
        .pe_valid        (pe_valid),
        .pe_load_old     (pe_load_old),
        .out_we          (out_we),
        .out_re          (out_re),
        .out_addr        (out_addr),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .busy            (busy),
        .done            (done),
        .step            (step)
`ifdef DOTP_SEQ_PERF_EN
        ,
        .perf_cycles     (perf_cycles),
        .perf_stalls     (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t sample_outputs();
        vec_t v;
        v = {load_ready, mem_we_in, mem_waddr, mem_re, mem_raddr, pe_clear, pe_valid,
             pe_load_old, out_we, out_re, out_addr, wb_valid, busy, done, step};
        return v;
    endfunction

    task automatic check_vec(input string tag, input int t, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One job: random load_valid/wb_ready with optional directed gap, stall and mid-job reset.
    task automatic run_job(input string tag, input int lv_pct, input int wr_pct,
                           input logic old, input logic [AW-1:0] raddr,
                           input int gap_t, input int gap_len,
                           input int stall_beat, input int stall_len, input int abort_t);
        logic lv [0:MAXT-1];
        logic wr [0:MAXT-1];
        vec_t ev [0:MAXT-1];
        vec_t ob [0:MAXT];
        int   acc_t [0:BEATS-1];
        int   rd_t [0:BEATS-1];
        int   hs_t [0:BEATS-1];
        int   n, l_last, c_t, k_t, d_t, t_end, rt, h, k, stalls;

        for (int t = 0; t < MAXT; t++) begin
            lv[t] = (t >= 200) || ($urandom_range(1, 100) <= lv_pct);
            wr[t] = (t >= 200) || ($urandom_range(1, 100) <= wr_pct);
            ev[t] = '0;
        end
        for (int t = gap_t; t < gap_t + gap_len; t++) lv[t] = 1'b0;

        n = 0;
        for (int t = 0; t < MAXT && n < BEATS; t++) begin
            if (lv[t]) begin
                acc_t[n] = t;
                n++;
            end
        end
        l_last = acc_t[BEATS-1];
        c_t    = l_last + 1;
        k_t    = c_t + BEATS + STAGES;
        rt     = k_t + 1;
        for (int b = 0; b < BEATS; b++) begin
            rd_t[b] = rt;
            if (b == stall_beat) begin
                for (int j = 1; j <= stall_len; j++) wr[rt + j] = 1'b0;
                wr[rt + stall_len + 1] = 1'b1;
            end
            h = rt + 1;
            while (!wr[h]) h++;
            hs_t[b] = h;
            rt = h + 1;
        end
        d_t = rt;

        k = 0;
        stalls = 0;
        for (int t = 0; t <= l_last; t++) begin
            ev[t].busy = 1'b1;
            ev[t].lr   = 1'b1;
            ev[t].step = SW'(k);
            ev[t].wa   = AW'(k);
            ev[t].we   = lv[t];
            if (lv[t]) k++;
            else stalls++;
        end
        for (int s = 0; s < BEATS + STAGES; s++) begin
            ev[c_t + s].busy = 1'b1;
            ev[c_t + s].step = SW'(s);
            if (s < BEATS) begin
                ev[c_t + s].re     = 1'b1;
                ev[c_t + s].ra     = AW'(s);
                ev[c_t + s + 1].pv = 1'b1;
            end
        end
        ev[c_t].clr = 1'b1;
        ev[c_t].plo = old;
        ev[k_t].busy = 1'b1;
        ev[k_t].owe  = 1'b1;
        ev[k_t].oa   = raddr;
        for (int b = 0; b < BEATS; b++) begin
            ev[rd_t[b]].busy = 1'b1;
            ev[rd_t[b]].ore  = 1'b1;
            ev[rd_t[b]].oa   = AW'(b);
            ev[rd_t[b]].step = SW'(b);
            for (int t = rd_t[b] + 1; t <= hs_t[b]; t++) begin
                ev[t].busy = 1'b1;
                ev[t].wv   = 1'b1;
                ev[t].oa   = AW'(b);
                ev[t].step = SW'(b);
            end
            stalls += hs_t[b] - rd_t[b] - 1;
        end
        ev[d_t].busy = 1'b1;
        ev[d_t].done = 1'b1;

        if (abort_t >= 0) begin
            for (int t = abort_t + 1; t < MAXT; t++) ev[t] = '0;
            t_end = abort_t + 3;
        end else begin
            t_end = d_t + 1;
        end

        for (int t = -1; t <= t_end; t++) begin
            @(posedge clk);
            #1;
            if (t < 0) begin
                start           = 1'b1;
                load_old_output = old;
                result_addr     = raddr;
                load_valid      = 1'($urandom_range(0, 1));
                wb_ready        = 1'($urandom_range(0, 1));
                reset_n         = 1'b1;
            end else begin
                if (abort_t >= 0) start = (t == abort_t) ? 1'b1 : ((t < abort_t) ? ($urandom_range(0, 3) == 0) : 1'b0);
                else start = (t < d_t) ? ($urandom_range(0, 3) == 0) : 1'b0;
                load_old_output = 1'($urandom_range(0, 1));
                result_addr     = AW'($urandom_range(0, 15));
                load_valid      = lv[t];
                wb_ready        = wr[t];
                reset_n         = (t == abort_t) ? 1'b0 : 1'b1;
            end
            @(negedge clk);
            ob[t + 1] = sample_outputs();
        end

        for (int t = -1; t <= t_end; t++) begin
            check_vec(tag, t, ob[t + 1], (t < 0) ? vec_t'('0) : ev[t]);
        end
`ifdef DOTP_SEQ_PERF_EN
        if (abort_t >= 0) begin
            check_val({tag, "_perf_cycles"}, perf_cycles, 32'd0);
            check_val({tag, "_perf_stalls"}, perf_stalls, 32'd0);
        end else begin
            check_val({tag, "_perf_cycles"}, perf_cycles, 32'(d_t + 2));
            check_val({tag, "_perf_stalls"}, perf_stalls, 32'(stalls));
        end
`endif
    endtask

    initial begin
        // Reset held with start and every other input active: reset must win.
        reset_n         = 1'b0;
        start           = 1'b1;
        load_old_output = 1'b1;
        result_addr     = 4'hF;
        load_valid      = 1'b1;
        wb_ready        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        start      = 1'b0;
        load_valid = 1'b0;
        wb_ready   = 1'b0;
        @(negedge clk);
        check_vec("reset_idle", 0, sample_outputs(), '0);
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        wb_ready   = 1'b1;
        @(negedge clk);
        check_vec("idle_ignores_inputs", 1, sample_outputs(), '0);
`ifdef DOTP_SEQ_PERF_EN
        check_val("reset_perf_cycles", perf_cycles, 32'd0);
        check_val("reset_perf_stalls", perf_stalls, 32'd0);
`endif

        run_job("b2b_default", 100, 100, 1'b0, 4'd5, 0, 0, -1, 0, -1);
        run_job("load_gap", 100, 100, 1'b0, 4'd9, 8, 3, -1, 0, -1);
        run_job("wb_backpressure", 100, 100, 1'b0, 4'd3, 0, 0, 2, 4, -1);
        run_job("old_output", 100, 100, 1'b1, 4'd12, 0, 0, -1, 0, -1);
        for (int i = 0; i < 4; i++) begin
            run_job("random_job", $urandom_range(30, 100), $urandom_range(30, 100),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 0, 0, -1, 0, -1);
        end
        run_job("mid_job_reset", 100, 100, 1'b1, 4'd7, 0, 0, -1, 0, 25);
        run_job("after_reset", 100, 100, 1'b0, 4'd5, 0, 0, -1, 0, -1);
        run_job("random_stall", 70, 60, 1'b1, 4'd15, 2, 2, 15, 3, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Control FSM that sequences one dot-product job on the existing datapath of two input SRAMs, one output SRAM and the pipelined MAC PE.
- Phases: LOAD (stream operands from host into the input SRAMs), COMPUTE (issue reads, feed PE, drain pipeline, commit result), WRITEBACK (stream the output SRAM back to host).
- Replaces the hand-timed Mem_reset/Computing/load_from_file/write_to_file pulsing with start/done and valid/ready handshakes.

Parameters:
- Addr_Width, 4, SRAM address width.
- Nums_Data, 16, elements per operand vector; must be ≤ 2^Addr_Width and a multiple of Para_Deg.
- Nums_Pipeline_Stages, 4, PE pipeline depth in cycles.
- Para_Deg, 1, lanes per SRAM word; Beats = Nums_Data/Para_Deg.
- Step_Width, 6, width of the step counter; must hold Beats+Nums_Pipeline_Stages.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- load_old_output  in  1  sampled with start; PE accumulates onto the old output word.
- result_addr  in  Addr_Width  sampled with start; output-SRAM address for the result.
- load_valid  in  1  host operand beat valid.
- load_ready  out  1  sequencer accepts an operand beat.
- mem_we_in  out  1  write enable, both input SRAMs.
- mem_waddr  out  Addr_Width  input-SRAM write address.
- mem_re  out  1  read enable, input SRAMs.
- mem_raddr  out  Addr_Width  input-SRAM read address.
- pe_clear  out  1  clear PE accumulator/pipeline.
- pe_valid  out  1  PE operand valid (read data present).
- pe_load_old  out  1  PE preloads the old output word.
- out_we  out  1  output-SRAM write (result commit).
- out_re  out  1  output-SRAM read (writeback).
- out_addr  out  Addr_Width  output-SRAM address for out_we/out_re.
- wb_valid  out  1  writeback beat valid; data comes from the output SRAM.
- wb_ready  in  1  host accepts writeback beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- step  out  Step_Width  current phase counter.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, all outputs 0, counters 0, latched config 0. Reset takes effect from any state, mid-job included, and aborts with no done pulse.
- States: IDLE → LOAD → COMPUTE → COMMIT → WB_READ ⇄ WB_SEND → DONE → IDLE.
- IDLE: on start=1, latch load_old_output/result_addr, go to LOAD. start is ignored in all other states.
- LOAD:
  - load_ready=1.
  - On each load_valid&load_ready: mem_we_in=1 combinationally, mem_waddr=step, step+1.
  - After beat Beats-1 is accepted: step←0, pe_clear=1 for exactly the next cycle, go to COMPUTE.
  - Stalls indefinitely while load_valid=0.
- COMPUTE: step runs 0..Beats+Nums_Pipeline_Stages-1, one per cycle, with no stall.
  - mem_re=1 and mem_raddr=step while step<Beats.
  - pe_valid is mem_re delayed one cycle (SRAM read latency 1).
  - pe_load_old=1 on step 0 only, if latched load_old_output=1.
  - At the last step go to COMMIT.
- COMMIT: one cycle, out_we=1, out_addr=result_addr; step←0.
- WB_READ: out_re=1, out_addr=step; next cycle go to WB_SEND.
- WB_SEND:
  - wb_valid=1, held with data stable until wb_ready.
  - On handshake: if step=Beats-1 go to DONE, else step+1 and go to WB_READ.
  - Minimum 2 cycles per beat.
- DONE: done=1 for one cycle, busy=1; go to IDLE.
- Address arithmetic is Addr_Width unsigned; the step counter never wraps within a job.
- Simultaneous start with reset_n=0: reset wins.
- wb_ready outside WB_SEND is ignored; load_valid outside LOAD is ignored, with no write.

Optional Feature:
- Macro DOTP_SEQ_PERF_EN.
- Defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts busy cycles of the last job.
  - perf_stalls counts LOAD cycles with load_valid=0 plus WB_SEND cycles with wb_ready=0.
  - Both clear on start acceptance, hold after DONE, and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1 → every output 0, busy=0; start=1 → busy=1 next cycle, load_ready=1.
- Back-to-back load, defaults: 16 beats with load_valid held high → mem_waddr 0..15 on consecutive cycles; pe_clear exactly one cycle later; mem_re 16 cycles; out_we exactly 20 cycles after pe_clear with out_addr=result_addr (e.g. 5).
- Load gaps: load_valid low for 3 cycles after beat 7 → load_ready stays 1, no mem_we_in during the gap, beat 8 written at address 8; COMPUTE timing unchanged.
- Writeback backpressure: wb_ready low for 4 cycles on beat 2 → wb_valid stays 1 and out_addr stays 2; 16 beats total, done pulse once, then busy=0.
- Old-output mode: start with load_old_output=1 → pe_load_old=1 only on COMPUTE step 0; with load_old_output=0 it never asserts.
- Mid-job reset: reset_n=0 during COMPUTE step 9 → next cycle IDLE, every output 0, no done; a new start then completes normally (with DOTP_SEQ_PERF_EN: perf_cycles=16+1+20+1+32+1=71 for a zero-stall job).
